wb_reg_file: RTL and testbench

Architectural integer register file and write-back consumer for the RV32I pipeline. It takes the selected write-back word from the WB stage and commits it to one of 32 registers. It serves two combinational read ports to the ID stage. It keeps a pending-write scoreboard so ID can stall on registers whose producer has not yet written back.

---
 rtl/wb_reg_file_if.sv | 29 ++
 rtl/wb_reg_file.sv | 81 ++++++++
 tb/tb_wb_reg_file.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_reg_file_if.sv
// Write-back / read / issue bus between the pipeline and the register file.
// master: pipeline side (drives indices, write-back and issue).
// slave:  register file side (returns read data and busy flags).
interface wb_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWE;
  logic [ADDR_W-1:0] wR;
  logic [DATA_W-1:0] RegWd;
  logic [ADDR_W-1:0] rR1;
  logic [ADDR_W-1:0] rR2;
  logic [DATA_W-1:0] rD1;
  logic [DATA_W-1:0] rD2;
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueRd;
  logic              Busy1;
  logic              Busy2;

  modport master (
    output RegWE, wR, RegWd, rR1, rR2, IssueValid, IssueRd,
    input  rD1, rD2, Busy1, Busy2
  );

  modport slave (
    input  RegWE, wR, RegWd, rR1, rR2, IssueValid, IssueRd,
    output rD1, rD2, Busy1, Busy2
  );
endinterface

// File: rtl/wb_reg_file.sv
// RV32I architectural register file with write-back port, two combinational
// read ports and a pending-write scoreboard for ID-stage stalls.
// Optional feature macro: REGFILE_BYPASS_EN (write-through read bypass and
// busy masking for the register being written back this cycle).
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_reg_file_if.slave     bus
);
  localparam int DEPTH = 1 << ADDR_W;

  // x0 is not stored; reads of index 0 are forced to zero below.
  logic [DATA_W-1:0] r_regs [1:DEPTH-1];
  logic [DEPTH-1:1]  r_pending;

  logic              w_wen;
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic              w_busy1, w_busy2;

  assign w_wen = bus.RegWE && (bus.wR != '0);

  // Commit the write-back word; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wen) begin
      r_regs[bus.wR] <= bus.RegWd;
    end
  end

  // Scoreboard: a new issue wins over a same-cycle write-back, since the
  // newer producer still has to write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (bus.IssueValid && (bus.IssueRd == ADDR_W'(i)))
          r_pending[i] <= 1'b1;
        else if (w_wen && (bus.wR == ADDR_W'(i)))
          r_pending[i] <= 1'b0;
      end
    end
  end

  // Read ports and busy flags, purely combinational.
  always_comb begin
    w_rd1   = '0;
    w_rd2   = '0;
    w_busy1 = 1'b0;
    w_busy2 = 1'b0;
    if (bus.rR1 != '0) begin
      w_rd1   = r_regs[bus.rR1];
      w_busy1 = r_pending[bus.rR1];
    end
    if (bus.rR2 != '0) begin
      w_rd2   = r_regs[bus.rR2];
      w_busy2 = r_pending[bus.rR2];
    end
`ifdef REGFILE_BYPASS_EN
    // Write-through: the word being written back is visible this cycle and
    // its destination no longer stalls.
    if (w_wen && (bus.wR == bus.rR1)) begin
      w_rd1   = bus.RegWd;
      w_busy1 = 1'b0;
    end
    if (w_wen && (bus.wR == bus.rR2)) begin
      w_rd2   = bus.RegWd;
      w_busy2 = 1'b0;
    end
`endif
  end

  assign bus.rD1   = w_rd1;
  assign bus.rD2   = w_rd2;
  assign bus.Busy1 = w_busy1;
  assign bus.Busy2 = w_busy2;
endmodule

// File: tb/tb_wb_reg_file.sv
// Directed self-checking bench for wb_reg_file. Expectations follow the
// REGFILE_BYPASS_EN setting the bench is compiled with.
module tb_wb_reg_file;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  wb_reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RegWE      = 1'b0;
    bus.wR         = '0;
    bus.RegWd      = '0;
    bus.IssueValid = 1'b0;
    bus.IssueRd    = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.rR1 = 5'd5;
    bus.rR2 = 5'd5;
    #2;
    check("reset_rd1", bus.rD1, 32'h0);
    check("reset_busy1", {31'b0, bus.Busy1}, 32'h0);
    check("reset_rd2", bus.rD2, 32'h0);
    #10 rst_n = 1'b1;
    tick();

    // Write x5 and issue a producer to x5, then reset asynchronously.
    bus.RegWE = 1'b1; bus.wR = 5'd5; bus.RegWd = 32'hDEADBEEF;
    tick();
    idle();
    bus.IssueValid = 1'b1; bus.IssueRd = 5'd5;
    tick();
    idle();
    #1;
    check("pre_rst_rd1", bus.rD1, 32'hDEADBEEF);
    check("pre_rst_busy1", {31'b0, bus.Busy1}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rd1", bus.rD1, 32'h0);
    check("async_rst_busy1", {31'b0, bus.Busy1}, 32'h0);
    tick();
    check("held_rst_rd2", bus.rD2, 32'h0);
    #2 rst_n = 1'b1;
    tick();

    // x0 hardwire: write and issue to x0 have no effect.
    bus.rR1 = 5'd0;
    bus.RegWE = 1'b1; bus.wR = 5'd0; bus.RegWd = 32'hFFFFFFFF;
    bus.IssueValid = 1'b1; bus.IssueRd = 5'd0;
    #1;
    check("x0_same_cycle_rd1", bus.rD1, 32'h0);
    tick();
    idle();
    #1;
    check("x0_rd1", bus.rD1, 32'h0);
    check("x0_busy1", {31'b0, bus.Busy1}, 32'h0);

    // Basic write/read through port 2.
    bus.rR2 = 5'd7;
    bus.RegWE = 1'b1; bus.wR = 5'd7; bus.RegWd = 32'h12345678;
    #1;
    check("wr_cycleN_rd2", bus.rD2, BYP ? 32'h12345678 : 32'h0);
    tick();
    idle();
    #1;
    check("wr_after_rd2", bus.rD2, 32'h12345678);

    // Scoreboard set and clear on x3.
    bus.rR1 = 5'd3;
    bus.IssueValid = 1'b1; bus.IssueRd = 5'd3;
    #1;
    check("sb_before_edge", {31'b0, bus.Busy1}, 32'h0);
    tick();
    idle();
    #1;
    check("sb_set_busy1", {31'b0, bus.Busy1}, 32'h1);
    tick();
    check("sb_hold_busy1", {31'b0, bus.Busy1}, 32'h1);
    bus.RegWE = 1'b1; bus.wR = 5'd3; bus.RegWd = 32'h00000033;
    #1;
    check("sb_wb_cycle_busy1", {31'b0, bus.Busy1}, BYP ? 32'h0 : 32'h1);
    check("sb_wb_cycle_rd1", bus.rD1, BYP ? 32'h33 : 32'h0);
    tick();
    idle();
    #1;
    check("sb_clr_busy1", {31'b0, bus.Busy1}, 32'h0);
    check("sb_clr_rd1", bus.rD1, 32'h33);

    // Simultaneous set and clear on x9: set wins, data still written.
    bus.rR1 = 5'd9; bus.rR2 = 5'd9;
    bus.IssueValid = 1'b1; bus.IssueRd = 5'd9;
    tick();
    bus.RegWE = 1'b1; bus.wR = 5'd9; bus.RegWd = 32'h000000A5;
    tick();
    idle();
    #1;
    check("setclr_busy1", {31'b0, bus.Busy1}, 32'h1);
    check("setclr_busy2", {31'b0, bus.Busy2}, 32'h1);
    check("setclr_rd1", bus.rD1, 32'hA5);
    bus.RegWE = 1'b1; bus.wR = 5'd9; bus.RegWd = 32'h000000B6;
    tick();
    idle();
    #1;
    check("setclr_final_busy2", {31'b0, bus.Busy2}, 32'h0);
    check("setclr_final_rd2", bus.rD2, 32'hB6);

    // Clear of a non-pending register: data written, no busy.
    bus.rR1 = 5'd20;
    bus.RegWE = 1'b1; bus.wR = 5'd20; bus.RegWd = 32'hCAFEF00D;
    tick();
    idle();
    #1;
    check("nopend_busy1", {31'b0, bus.Busy1}, 32'h0);
    check("nopend_rd1", bus.rD1, 32'hCAFEF00D);

    // Dual-port conflict on x12.
    bus.rR1 = 5'd12; bus.rR2 = 5'd12;
    bus.IssueValid = 1'b1; bus.IssueRd = 5'd12;
    tick();
    idle();
    #1;
    check("dual_busy_pair", {30'b0, bus.Busy1, bus.Busy2}, 32'h3);
    bus.RegWE = 1'b1; bus.wR = 5'd12; bus.RegWd = 32'h55AA55AA;
    #1;
    check("dual_cycleN_rd1", bus.rD1, BYP ? 32'h55AA55AA : 32'h0);
    check("dual_cycleN_rd2", bus.rD2, BYP ? 32'h55AA55AA : 32'h0);
    check("dual_cycleN_busy", {30'b0, bus.Busy1, bus.Busy2}, BYP ? 32'h0 : 32'h3);
    tick();
    idle();
    #1;
    check("dual_after_rd1", bus.rD1, 32'h55AA55AA);
    check("dual_after_rd2", bus.rD2, 32'h55AA55AA);
    check("dual_after_busy", {30'b0, bus.Busy1, bus.Busy2}, 32'h0);

    // Earlier registers untouched by later traffic.
    bus.rR1 = 5'd7; bus.rR2 = 5'd3;
    #1;
    check("keep_x7", bus.rD1, 32'h12345678);
    check("keep_x3", bus.rD2, 32'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
